multdiv_unit: RTL and testbench
===============================

MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are 4..64.
REQ-002 The module SHALL have parameter SIGNED_MODE, default 1; 1 selects two's-complement arithmetic, 0 selects unsigned arithmetic.
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock, rising-edge active.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port data_operandA, input, WIDTH bits: multiplicand or dividend.
REQ-006 The module SHALL have port data_operandB, input, WIDTH bits: multiplier or divisor.
REQ-007 The module SHALL have port ctrl_MULT, input, 1 bit: single-cycle multiply start pulse.
REQ-008 The module SHALL have port ctrl_DIV, input, 1 bit: single-cycle divide start pulse.
REQ-009 The module SHALL have port data_result, output, WIDTH bits: low product word or quotient.
REQ-010 The module SHALL have port data_remainder, output, WIDTH bits: remainder after a divide, 0 after a multiply.
REQ-011 The module SHALL have port data_exception, output, 1 bit: error flag, valid while data_resultRDY=1.
REQ-012 The module SHALL have port data_resultRDY, output, 1 bit: one-cycle completion pulse.
REQ-013 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.

Function
REQ-014 Start rules: a start is sampled on an edge where ctrl_MULT or ctrl_DIV is 1; operands are latched at that edge and need not be held afterwards.
REQ-015 Simultaneous starts: if ctrl_MULT=ctrl_DIV=1, the operation is a multiply.
REQ-016 FSM: states IDLE, RUN and DONE; start goes to RUN from any state; RUN runs an internal counter for WIDTH cycles, then goes to DONE; DONE goes to IDLE after one cycle.
REQ-017 Latency: for a start sampled at edge E0, data_resultRDY is 1 for exactly the cycle following edge E0+WIDTH+1 and 0 at all other times; latency is identical for multiply and divide, including exception cases.
REQ-018 busy is 1 from edge E0 until edge E0+WIDTH+1, and 0 in DONE and IDLE.
REQ-019 data_result, data_remainder and data_exception update only on entry to DONE and hold until the next DONE or reset; they never show intermediate values.
REQ-020 Restart: a start during RUN or DONE aborts the current operation without any RDY pulse for it, and restarts timing from the new edge E0.
REQ-021 Multiply: data_result is the low WIDTH bits of the full 2*WIDTH-bit product, computed by shift-add (radix-2) over WIDTH iterations.
REQ-022 Multiply exception: data_exception=1 when the full product is not representable in WIDTH bits; signed mode uses the signed range, unsigned mode uses the unsigned range.
REQ-023 Divide: the quotient truncates toward zero; the remainder takes the sign of the dividend; the algorithm is iterative restoring or non-restoring over WIDTH iterations on magnitudes, with final sign correction in signed mode.
REQ-024 Divide by zero: data_result=0, data_remainder=dividend, data_exception=1.
REQ-025 Signed overflow: the case most-negative / -1 (SIGNED_MODE=1) gives data_result=most-negative, data_remainder=0, data_exception=1.
REQ-026 In unsigned mode, no divide exception other than divide by zero occurs.

Reset
REQ-027 When reset=1 at an edge, the state SHALL be IDLE, and data_result, data_remainder, data_exception, data_resultRDY and busy SHALL all be 0.
REQ-028 Reset has priority over a simultaneous start; reset during RUN aborts the operation with no RDY pulse.

Verification (WIDTH=32, SIGNED_MODE=1 unless stated)
REQ-029 Scenario: MULT 7 x 0xFFFFFFFA -> after 33 cycles RDY for one cycle; result 0xFFFFFFD6, remainder 0, exception 0; busy=1 for exactly 33 cycles.
REQ-030 Scenario: MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1; with SIGNED_MODE=0, 0xFFFFFFFF x 1 -> result 0xFFFFFFFF, exception 0.
REQ-031 Scenario: DIV 0xFFFFFFF9 / 2 -> result 0xFFFFFFFD, remainder 0xFFFFFFFF, exception 0; DIV 5 / 0 -> result 0, remainder 5, exception 1.
REQ-032 Scenario: DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000, remainder 0, exception 1.
REQ-033 Scenario: MULT 3 x 4 started, then DIV 100 / 7 pulsed 10 cycles later -> exactly one RDY, 33 cycles after the DIV edge; result 14, remainder 2.
REQ-034 Scenario: MULT started, reset asserted 5 cycles later for 1 cycle -> no RDY; all outputs 0; a following MULT 2 x 3 returns 6 with normal latency.

Source files
------------

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative radix-2 multiply / restoring divide unit
//
// Purpose: shift-add multiplier and restoring divider sharing one IDLE/RUN/DONE
// sequencer. An operation takes WIDTH iterations plus one finalize cycle.
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous active-high reset
//   data_operandA  - multiplicand / dividend (latched at start)
//   data_operandB  - multiplier / divisor (latched at start)
//   ctrl_MULT      - multiply start pulse (wins over ctrl_DIV)
//   ctrl_DIV       - divide start pulse
//   data_result    - low product word or quotient
//   data_remainder - remainder after divide, 0 after multiply
//   data_exception - overflow / divide-by-zero flag
//   data_resultRDY - one-cycle completion pulse (the DONE state)
//   busy           - operation in progress (the RUN state)
module multdiv_unit #(
    parameter int WIDTH       = 32,
    parameter bit SIGNED_MODE = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t r_state, w_next;

    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;     // quotient / product sign
    logic               r_neg_r;     // remainder sign follows dividend
    logic [WIDTH-1:0]   r_opa, r_opb;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_dsor;
    logic [WIDTH-1:0]   r_result, r_remainder;
    logic               r_exception;

    logic               w_start, w_last;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_div_shift, w_div_diff;
    logic [2*WIDTH-1:0] w_prod_full;
    logic [WIDTH:0]     w_prod_top;
    logic               w_mul_exc;
    logic [WIDTH-1:0]   w_fin_res, w_fin_rem;
    logic               w_fin_exc;

    assign w_start = ctrl_MULT | ctrl_DIV;
    assign w_last  = (r_state == S_RUN) && (r_cnt == LAST);

    // Operate on magnitudes; the most-negative value maps to 2^(WIDTH-1),
    // which is still correct when read as unsigned.
    assign w_a_neg = SIGNED_MODE && data_operandA[WIDTH-1];
    assign w_b_neg = SIGNED_MODE && data_operandB[WIDTH-1];
    assign w_a_mag = w_a_neg ? -data_operandA : data_operandA;
    assign w_b_mag = w_b_neg ? -data_operandB : data_operandB;

    // Restoring divide step: shift next dividend bit into the partial
    // remainder and subtract when it does not borrow.
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_dsor};

    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_start) begin
            w_next = S_RUN;
        end else begin
            case (r_state)
                S_RUN:   if (w_last) w_next = S_DONE;
                S_DONE:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Final sign correction and exception detection.
    always_comb begin
        w_prod_full = r_neg_q ? -r_prod : r_prod;
        w_prod_top  = w_prod_full[2*WIDTH-1:WIDTH-1];
        if (SIGNED_MODE) w_mul_exc = !((&w_prod_top) || !(|w_prod_top));
        else             w_mul_exc = |r_prod[2*WIDTH-1:WIDTH];
        w_fin_res = w_prod_full[WIDTH-1:0];
        w_fin_rem = '0;
        w_fin_exc = w_mul_exc;
        if (r_is_div) begin
            if (r_opb == '0) begin
                w_fin_res = '0;
                w_fin_rem = r_opa;
                w_fin_exc = 1'b1;
            end else begin
                // most-negative / -1 already yields most-negative, rem 0.
                w_fin_res = r_neg_q ? -r_quo : r_quo;
                w_fin_rem = r_neg_r ? -r_rem : r_rem;
                w_fin_exc = SIGNED_MODE && (r_opa == MOST_NEG) && (&r_opb);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_mplier    <= '0;
            r_mcand     <= '0;
            r_prod      <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_dsor      <= '0;
            r_result    <= '0;
            r_remainder <= '0;
            r_exception <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= '0;
            r_is_div <= !ctrl_MULT;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_opa    <= data_operandA;
            r_opb    <= data_operandB;
            r_mplier <= w_b_mag;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_prod   <= '0;
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            r_dsor   <= w_b_mag;
        end else if (r_state == S_RUN) begin
            if (w_last) begin
                r_result    <= w_fin_res;
                r_remainder <= w_fin_rem;
                r_exception <= w_fin_exc;
            end else begin
                // Both datapaths step every cycle; only one result is used.
                r_cnt    <= r_cnt + CW'(1);
                if (r_mplier[0]) r_prod <= r_prod + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                if (!w_div_diff[WIDTH]) begin
                    r_rem <= w_div_diff[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                end else begin
                    r_rem <= w_div_shift[WIDTH-1:0];
                    r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    assign data_result    = r_result;
    assign data_remainder = r_remainder;
    assign data_exception = r_exception;
    assign data_resultRDY = (r_state == S_DONE);
    assign busy           = (r_state == S_RUN);

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed vector bench for multdiv_unit
module tb_multdiv_unit;

    localparam int W = 32;

    typedef struct {
        bit          is_div;
        bit          uns;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [31:0] rem;
        bit          exc;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] opA = '0, opB = '0;
    logic        mult = 1'b0, div = 1'b0;

    logic [31:0] s_res, s_rem, u_res, u_rem;
    logic        s_exc, s_rdy, s_busy, u_exc, u_rdy, u_busy;

    bit          use_u = 1'b0;
    logic [31:0] q_res, q_rem;
    logic        q_exc, q_rdy, q_busy;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    multdiv_unit #(.WIDTH(32), .SIGNED_MODE(1'b1)) dut_s (
        .clock(clock), .reset(reset),
        .data_operandA(opA), .data_operandB(opB),
        .ctrl_MULT(mult), .ctrl_DIV(div),
        .data_result(s_res), .data_remainder(s_rem),
        .data_exception(s_exc), .data_resultRDY(s_rdy), .busy(s_busy)
    );

    multdiv_unit #(.WIDTH(32), .SIGNED_MODE(1'b0)) dut_u (
        .clock(clock), .reset(reset),
        .data_operandA(opA), .data_operandB(opB),
        .ctrl_MULT(mult), .ctrl_DIV(div),
        .data_result(u_res), .data_remainder(u_rem),
        .data_exception(u_exc), .data_resultRDY(u_rdy), .busy(u_busy)
    );

    always_comb begin
        q_res  = use_u ? u_res  : s_res;
        q_rem  = use_u ? u_rem  : s_rem;
        q_exc  = use_u ? u_exc  : s_exc;
        q_rdy  = use_u ? u_rdy  : s_rdy;
        q_busy = use_u ? u_busy : s_busy;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit is_div, input bit uns, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] res,
                                input logic [31:0] rem, input bit exc);
        vec_t v;
        v.is_div = is_div; v.uns = uns; v.a = a; v.b = b;
        v.res = res; v.rem = rem; v.exc = exc;
        return v;
    endfunction

    // Drives a start pulse; returns at the negedge right after the start edge.
    task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        opA = a; opB = b; mult = !is_div; div = is_div;
        @(posedge clock);
        @(negedge clock);
        mult = 1'b0; div = 1'b0;
        opA = $urandom; opB = $urandom;
    endtask

    // k counts cycles after the start edge; k=0 is the current negedge.
    task automatic monitor(output int rdy_cnt, output int rdy_k,
                           output int busy_cnt, output int hold_bad);
        logic [31:0] r0, m0;
        logic        e0;
        rdy_cnt = 0; rdy_k = -1; busy_cnt = 0; hold_bad = 0;
        r0 = q_res; m0 = q_rem; e0 = q_exc;
        for (int k = 0; k < W + 6; k++) begin
            if (k > 0) @(negedge clock);
            if (q_rdy) begin rdy_cnt++; rdy_k = k; end
            if (q_busy) busy_cnt++;
            if (k <= W && (q_res !== r0 || q_rem !== m0 || q_exc !== e0)) hold_bad++;
        end
    endtask

    task automatic check_run(input string tag, input logic [31:0] res,
                             input logic [31:0] rem, input bit exc);
        int rc, rk, bc, hb;
        monitor(rc, rk, bc, hb);
        chk({tag, " rdy_count"}, rc, 1);
        chk({tag, " rdy_cycle"}, rk, W + 1);
        chk({tag, " busy_cycles"}, bc, W + 1);
        chk({tag, " no_early_update"}, hb, 0);
        chk({tag, " result"}, q_res, res);
        chk({tag, " remainder"}, q_rem, rem);
        chk({tag, " exception"}, q_exc, exc);
    endtask

    vec_t vt[15];

    initial begin
        int rc, rk, bc, hb;

        vt[0]  = mk(0, 0, 32'h7,        32'hFFFFFFFA, 32'hFFFFFFD6, 32'h0,        1'b0);
        vt[1]  = mk(0, 0, 32'h00010000, 32'h00010000, 32'h0,        32'h0,        1'b1);
        vt[2]  = mk(1, 0, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        vt[3]  = mk(1, 0, 32'h5,        32'h0,        32'h0,        32'h5,        1'b1);
        vt[4]  = mk(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b1);
        vt[5]  = mk(1, 0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
        vt[6]  = mk(0, 0, 32'h80000000, 32'h1,        32'h80000000, 32'h0,        1'b0);
        vt[7]  = mk(0, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b1);
        vt[8]  = mk(1, 0, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        1'b0);
        vt[9]  = mk(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0);
        vt[10] = mk(0, 1, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 32'h0,        1'b0);
        vt[11] = mk(0, 1, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFE, 32'h0,        1'b1);
        vt[12] = mk(1, 1, 32'hFFFFFFF9, 32'h2,        32'h7FFFFFFC, 32'h1,        1'b0);
        vt[13] = mk(1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0);
        vt[14] = mk(1, 1, 32'h9,        32'h0,        32'h0,        32'h9,        1'b1);

        // Reset state
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset result", s_res, 0);
        chk("reset remainder", s_rem, 0);
        chk("reset exception", s_exc, 0);
        chk("reset rdy", s_rdy, 0);
        chk("reset busy", s_busy, 0);

        // Reset wins over a simultaneous start
        @(negedge clock);
        reset = 1'b1; mult = 1'b1; opA = 32'd5; opB = 32'd5;
        @(negedge clock);
        reset = 1'b0; mult = 1'b0;
        chk("reset_priority busy", s_busy, 0);

        foreach (vt[i]) begin
            use_u = vt[i].uns;
            start_op(vt[i].is_div, vt[i].a, vt[i].b);
            check_run($sformatf("vec%0d", i), vt[i].res, vt[i].rem, vt[i].exc);
        end
        use_u = 1'b0;

        // Restart: DIV issued 10 cycles after a MULT aborts the MULT
        start_op(1'b0, 32'd3, 32'd4);
        rc = 0;
        repeat (9) begin
            @(negedge clock);
            if (s_rdy) rc++;
        end
        chk("restart early_rdy", rc, 0);
        opA = 32'd100; opB = 32'd7; div = 1'b1;
        @(posedge clock);
        @(negedge clock);
        div = 1'b0; opA = $urandom; opB = $urandom;
        check_run("restart", 32'd14, 32'd2, 1'b0);

        // Reset 5 cycles into a MULT: no RDY, outputs cleared
        start_op(1'b0, 32'd3, 32'd4);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        monitor(rc, rk, bc, hb);
        chk("abort rdy_count", rc, 0);
        chk("abort busy_cycles", bc, 0);
        chk("abort result", s_res, 0);
        chk("abort remainder", s_rem, 0);
        chk("abort exception", s_exc, 0);
        start_op(1'b0, 32'd2, 32'd3);
        check_run("after_abort", 32'd6, 32'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
